// File: rtl/mult_iter_unit.sv
// Iterative shift-add multiplier (MUL / MULHU), one multiplier bit per cycle.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier is 0.
module mult_iter_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              flush,
   input  logic              hi_sel,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2*DATA_W-1:0] mcand_q, mcand_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [2*DATA_W-1:0] acc_sum;
   logic [DATA_W-1:0]   mplr_q, mplr_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hi_q, hi_d;
   logic                done_q, done_d;
   logic                last_step;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplr_d    = mplr_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      done_d    = 1'b0;
      acc_sum   = acc_q + (mplr_q[0] ? mcand_q : '0);
      last_step = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               mcand_d = {{DATA_W{1'b0}}, op_a};
               mplr_d  = op_b;
               hi_d    = hi_sel;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
`ifdef MULT_EARLY_TERM_EN
               if (op_b == '0) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = '0;
               end
`endif
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d   = acc_sum;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               cnt_d   = cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
               last_step = (cnt_q == CNT_LAST) || (mplr_d == '0);
`else
               last_step = (cnt_q == CNT_LAST);
`endif
               if (last_step) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = hi_q ? acc_sum[2*DATA_W-1:DATA_W]
                                  : acc_sum[DATA_W-1:0];
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplr_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         hi_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplr_q   <= mplr_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         done_q   <= done_d;
      end
   end

   // Stall is combinational so the requesting instruction freezes in cycle 0.
   assign stall  = ((state_q == S_IDLE) && start && !flush)
                || (state_q == S_RUN);
   assign busy   = (state_q == S_RUN);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mult_iter_unit.sv
// Directed bench for mult_iter_unit (DATA_W=32).
// Expected latencies follow MULT_EARLY_TERM_EN when it is defined.
module tb_mult_iter_unit;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        flush;
   logic        hi_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

`ifdef MULT_EARLY_TERM_EN
   localparam int LAT_3X5 = 4;
   localparam int LAT_B0  = 1;
   localparam int LAT_B4  = 4;
   localparam int LAT_7X6 = 4;
   localparam int BB_D1   = 3;
   localparam int BB_D2   = 8;
`else
   localparam int LAT_3X5 = 33;
   localparam int LAT_B0  = 33;
   localparam int LAT_B4  = 33;
   localparam int LAT_7X6 = 33;
   localparam int BB_D1   = 33;
   localparam int BB_D2   = 67;
`endif

   mult_iter_unit #(.DATA_W(32)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .start  (start),
      .flush  (flush),
      .hi_sel (hi_sel),
      .op_a   (op_a),
      .op_b   (op_b),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp,
                            input int lat);
      int n;
      int bad;
      bad = 0;
      for (n = 1; n <= 200; n++) begin
         cyc();
         start = 1'b0;
         @(negedge clk);
         if (done === 1'b1) break;
         if (stall !== 1'b1 || busy !== 1'b1) bad++;
      end
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " result"}, result, exp);
      check({tag, " stall at done"}, {31'd0, stall}, 32'd0);
      check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
      check({tag, " stall gaps"}, 32'(bad), 32'd0);
      cyc();
      @(negedge clk);
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
      check({tag, " result held"}, result, exp);
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic hi,
                          input logic [31:0] exp, input int lat);
      cyc();
      start  = 1'b1;
      op_a   = a;
      op_b   = b;
      hi_sel = hi;
      @(negedge clk);
      check({tag, " stall cycle0"}, {31'd0, stall}, 32'd1);
      wait_done(tag, exp, lat);
   endtask

   initial begin
      int nd;
      int bad;
      int d1;
      int d2;
      logic [31:0] r1;
      logic [31:0] r2;

      arst_n = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      hi_sel = 1'b0;
      op_a   = '0;
      op_b   = '0;
      #12;
      check("reset stall", {31'd0, stall}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      run_mul("3x5", 32'd3, 32'd5, 1'b0, 32'd15, LAT_3X5);
      run_mul("ffxff hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              32'hFFFF_FFFE, 33);
      run_mul("ffxff lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              32'h0000_0001, 33);
      run_mul("b0", 32'd123, 32'd0, 1'b0, 32'd0, LAT_B0);
      run_mul("7x4", 32'd7, 32'd4, 1'b0, 32'd28, LAT_B4);
      run_mul("hi small", 32'd7, 32'd4, 1'b1, 32'd0, LAT_B4);

      run_mul("pre flush", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              32'h0000_0001, 33);
      cyc();
      start  = 1'b1;
      op_a   = 32'd9;
      op_b   = 32'h8000_0001;
      hi_sel = 1'b0;
      nd     = 0;
      bad    = 0;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         start = 1'b0;
         flush = (c == 10);
         @(negedge clk);
         if (done === 1'b1) nd++;
         if (stall !== 1'b1) bad++;
      end
      check("flush run stall", 32'(bad), 32'd0);
      check("flush no done before", 32'(nd), 32'd0);
      cyc();
      flush = 1'b0;
      @(negedge clk);
      check("flush idle stall", {31'd0, stall}, 32'd0);
      check("flush idle busy", {31'd0, busy}, 32'd0);
      check("flush idle done", {31'd0, done}, 32'd0);
      check("flush result kept", result, 32'h0000_0001);
      start = 1'b1;
      op_a  = 32'd7;
      op_b  = 32'h8000_0003;
      #1;
      check("post flush accept", {31'd0, stall}, 32'd1);
      wait_done("post flush", 32'h8000_0015, 33);

      cyc();
      start = 1'b1;
      op_a  = 32'h1234;
      op_b  = 32'h8000_0010;
      for (int c = 1; c <= 3; c++) begin
         cyc();
         start = 1'b0;
      end
      @(negedge clk);
      check("pre reset busy", {31'd0, busy}, 32'd1);
      #2;
      arst_n = 1'b0;
      #1;
      check("async rst stall", {31'd0, stall}, 32'd0);
      check("async rst busy", {31'd0, busy}, 32'd0);
      check("async rst done", {31'd0, done}, 32'd0);
      check("async rst result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in rst busy", {31'd0, busy}, 32'd0);
      arst_n = 1'b1;
      run_mul("7x6", 32'd7, 32'd6, 1'b0, 32'd42, LAT_7X6);

      cyc();
      start  = 1'b1;
      op_a   = 32'd2;
      op_b   = 32'd3;
      hi_sel = 1'b0;
      d1     = 0;
      d2     = 0;
      r1     = '0;
      r2     = '0;
      for (int n = 1; n <= 200; n++) begin
         cyc();
         if (n == 1) begin
            op_a = 32'd4;
            op_b = 32'd5;
         end
         @(negedge clk);
         if (done === 1'b1) begin
            if (d1 == 0) begin
               d1 = n;
               r1 = result;
            end else begin
               d2 = n;
               r2 = result;
               break;
            end
         end
      end
      cyc();
      start = 1'b0;
      @(negedge clk);
      check("b2b done1 cycle", 32'(d1), 32'(BB_D1));
      check("b2b result1", r1, 32'd6);
      check("b2b done2 cycle", 32'(d2), 32'(BB_D2));
      check("b2b result2", r2, 32'd20);
      check("b2b idle busy", {31'd0, busy}, 32'd0);
      check("b2b idle stall", {31'd0, stall}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
